// File: rtl/serial_link_ctrl.sv
// serial_link_ctrl: host-register driven 3-wire serial link controller.
// TX serialiser with programmable prescaler, RX deserialiser behind 2-FF
// synchronisers, RX FIFO and a registered status word.
// Optional even-parity framing is enabled by defining SERIAL_LINK_PARITY_EN.
module serial_link_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [REG_WIDTH-1:0]          pre_reg_i,
  input  logic [REG_WIDTH-1:0]          cmd_reg_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [REG_WIDTH-1:0]          status_reg_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
  output logic                          en_o,
  output logic                          sda_o,
  output logic                          scl_o,
  input  logic                          en_i,
  input  logic                          sda_i,
  input  logic                          scl_i
);

`ifdef SERIAL_LINK_PARITY_EN
  localparam int NBITS = DATA_WIDTH + 1;
`else
  localparam int NBITS = DATA_WIDTH;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_WAIT} rx_state_t;

  // Command edge detection
  logic [2:0] cmd_q;
  logic       start_edge, pop_edge, clr_edge;
  logic       unused_cmd;

  assign start_edge = cmd_reg_i[0] & ~cmd_q[0];
  assign pop_edge   = cmd_reg_i[1] & ~cmd_q[1];
  assign clr_edge   = cmd_reg_i[2] & ~cmd_q[2];
  assign unused_cmd = ^cmd_reg_i[REG_WIDTH-1:3];

  // Remember previous command bits so each action fires on a 0->1 transition
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cmd_q <= '0;
    else         cmd_q <= cmd_reg_i[2:0];
  end

  // ---------------- TX ----------------
  tx_state_t             tx_state;
  logic [REG_WIDTH-1:0]  tx_pre;
  logic [REG_WIDTH-1:0]  tx_div;
  logic [BIT_W-1:0]      tx_bit;
  logic [NBITS-1:0]      tx_sh;
  logic [NBITS-1:0]      tx_word;
  logic                  tx_load, tx_shift;

`ifdef SERIAL_LINK_PARITY_EN
  assign tx_word = {data_i, ^data_i};
`else
  assign tx_word = data_i;
`endif
  assign tx_load  = (tx_state == TX_IDLE) & start_edge;
  assign tx_shift = (tx_state == TX_SHIFT) & (tx_div == tx_pre) & scl_o & (tx_bit != LAST_BIT);

  // TX frame word: loaded on accepted start, shifted left at each bit boundary
  always_ff @(posedge clk_i) begin
    if (tx_load)       tx_sh <= tx_word;
    else if (tx_shift) tx_sh <= tx_sh << 1;
  end

  // TX FSM with registered link outputs; prescaler latched at start
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state <= TX_IDLE;
      tx_pre   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      en_o     <= 1'b0;
      sda_o    <= 1'b0;
      scl_o    <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (start_edge) begin
            tx_state <= TX_SHIFT;
            tx_pre   <= pre_reg_i;
            tx_div   <= '0;
            tx_bit   <= '0;
            en_o     <= 1'b1;
            scl_o    <= 1'b0;
            sda_o    <= tx_word[NBITS-1];
          end
        end
        TX_SHIFT: begin
          if (tx_div == tx_pre) begin
            tx_div <= '0;
            if (!scl_o) begin
              scl_o <= 1'b1;
            end else if (tx_bit == LAST_BIT) begin
              tx_state <= TX_IDLE;
              en_o     <= 1'b0;
              sda_o    <= 1'b0;
              scl_o    <= 1'b0;
            end else begin
              scl_o  <= 1'b0;
              tx_bit <= tx_bit + 1'b1;
              sda_o  <= tx_sh[NBITS-2];
            end
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [2:0] en_sync_p;
  logic [2:0] scl_sync_p;
  logic [1:0] sda_sync_p;
  logic       en_s, sda_s, en_rise, scl_rise;

  assign en_s     = en_sync_p[1];
  assign sda_s    = sda_sync_p[1];
  assign en_rise  = en_sync_p[1] & ~en_sync_p[2];
  assign scl_rise = scl_sync_p[1] & ~scl_sync_p[2];

  // Two-stage synchronisers plus one history stage for edge detection
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en_sync_p  <= '0;
      scl_sync_p <= '0;
      sda_sync_p <= '0;
    end else begin
      en_sync_p  <= {en_sync_p[1:0], en_i};
      scl_sync_p <= {scl_sync_p[1:0], scl_i};
      sda_sync_p <= {sda_sync_p[0], sda_i};
    end
  end

  rx_state_t         rx_state;
  logic [BIT_W-1:0]  rx_bit;
  logic [NBITS-1:0]  rx_sh;
  logic              rx_push;
  logic              rx_ferr;
  logic              rx_sample;
  logic              rx_perr;
  logic [DATA_WIDTH-1:0] rx_word;

  assign rx_sample = (rx_state == RX_SHIFT) & en_s & scl_rise;
  assign rx_ferr   = (rx_state == RX_SHIFT) & ~en_s & (rx_bit != '0);
`ifdef SERIAL_LINK_PARITY_EN
  assign rx_word = rx_sh[NBITS-1:1];
  assign rx_perr = rx_push & (^rx_sh);
`else
  assign rx_word = rx_sh;
  assign rx_perr = 1'b0;
`endif

  // RX shift register, MSB first
  always_ff @(posedge clk_i) begin
    if (rx_sample) rx_sh <= {rx_sh[NBITS-2:0], sda_s};
  end

  // RX FSM: frame opens on en rise, pushes one cycle after the last sample
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state <= RX_IDLE;
      rx_bit   <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (en_rise) begin
            rx_state <= RX_SHIFT;
            rx_bit   <= '0;
          end
        end
        RX_SHIFT: begin
          if (!en_s) begin
            rx_state <= RX_IDLE;
          end else if (scl_rise) begin
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == LAST_BIT) begin
              rx_push  <= 1'b1;
              rx_state <= RX_WAIT;
            end
          end
        end
        RX_WAIT: begin
          if (!en_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- FIFO and flags ----------------
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  pop_ok, wr_ok, ovf_c;
  logic                  ovf_q, ferr_q, perr_q;
  logic                  ovf_nxt, ferr_nxt, perr_nxt;
  logic [REG_WIDTH-1:0]  status_nxt;

  assign pop_ok = pop_edge & (rx_count_o != '0);
  assign wr_ok  = rx_push & ((rx_count_o != FULL_CNT) | pop_ok);
  assign ovf_c  = rx_push & (rx_count_o == FULL_CNT) & ~pop_ok;
  assign data_o = (rx_count_o != '0) ? fifo_mem[rd_ptr] : '0;

  // Next occupancy, sticky flags and status word
  always_comb begin
    count_nxt = rx_count_o;
    if (wr_ok && !pop_ok)      count_nxt = rx_count_o + 1'b1;
    else if (!wr_ok && pop_ok) count_nxt = rx_count_o - 1'b1;
    ovf_nxt  = (ovf_q  & ~clr_edge) | ovf_c;
    ferr_nxt = (ferr_q & ~clr_edge) | rx_ferr;
    perr_nxt = (perr_q & ~clr_edge) | rx_perr;
    status_nxt    = '0;
    status_nxt[0] = (tx_state == TX_SHIFT);
    status_nxt[1] = (count_nxt != '0);
    status_nxt[2] = (count_nxt == FULL_CNT);
    status_nxt[3] = ovf_nxt;
    status_nxt[4] = ferr_nxt;
    status_nxt[5] = perr_nxt;
  end

  // FIFO storage write
  always_ff @(posedge clk_i) begin
    if (wr_ok) fifo_mem[wr_ptr] <= rx_word;
  end

  // FIFO pointers, occupancy, sticky flags and registered status
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_count_o   <= '0;
      ovf_q        <= 1'b0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      status_reg_o <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      rx_count_o   <= count_nxt;
      ovf_q        <= ovf_nxt;
      ferr_q       <= ferr_nxt;
      perr_q       <= perr_nxt;
      status_reg_o <= status_nxt;
    end
  end

endmodule

// File: tb/tb_serial_link_ctrl.sv
// Directed bench for serial_link_ctrl (default build, plus a parity case
// when SERIAL_LINK_PARITY_EN is defined).
module tb_serial_link_ctrl;
`ifdef SERIAL_LINK_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [7:0] pre_reg_i = '0;
  logic [7:0] cmd_reg_i = '0;
  logic [7:0] data_i = '0;
  logic [7:0] data_o;
  logic [7:0] status_reg_o;
  logic [2:0] rx_count_o;
  logic       en_o, sda_o, scl_o;
  logic       en_i, sda_i, scl_i;
  logic       loop = 1'b0;
  logic       en_man = 1'b0, sda_man = 1'b0, scl_man = 1'b0;

  int tests = 0;
  int failed = 0;

  assign en_i  = loop ? en_o  : en_man;
  assign sda_i = loop ? sda_o : sda_man;
  assign scl_i = loop ? scl_o : scl_man;

  always #5 clk_i = ~clk_i;

  serial_link_ctrl #(.DATA_WIDTH(8), .REG_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pre_reg_i(pre_reg_i), .cmd_reg_i(cmd_reg_i),
    .data_i(data_i), .data_o(data_o), .status_reg_o(status_reg_o), .rx_count_o(rx_count_o),
    .en_o(en_o), .sda_o(sda_o), .scl_o(scl_o), .en_i(en_i), .sda_i(sda_i), .scl_i(scl_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
    tick(1);
  endtask

  task automatic pulse_cmd(input int b);
    cmd_reg_i[b] = 1'b1;
    tick(1);
    cmd_reg_i[b] = 1'b0;
    tick(1);
  endtask

  function automatic logic [15:0] frame_of(input logic [7:0] w);
    if (NB == 9) return {7'b0, w, ^w};
    return {8'b0, w};
  endfunction

  // Observe one TX frame starting at the first en_o=1 sample; optionally
  // re-issue start (with new data and prescaler) at cycle restart_at.
  task automatic capture(input int restart_at, output int en_cnt, output int busy_cnt,
                         output logic [15:0] bits, output int nbits, output int period);
    int   prev_rise;
    logic scl_prev;
    prev_rise = -1; scl_prev = 1'b0;
    en_cnt = 0; busy_cnt = 0; bits = '0; nbits = 0; period = 0;
    for (int c = 0; c < 600; c++) begin
      if (en_o) en_cnt++;
      if (status_reg_o[0]) busy_cnt++;
      if (scl_o && !scl_prev) begin
        bits = {bits[14:0], sda_o};
        nbits++;
        if (prev_rise >= 0) period = c - prev_rise;
        prev_rise = c;
      end
      scl_prev = scl_o;
      if (c == restart_at) begin
        cmd_reg_i[0] = 1'b1; data_i = 8'h0F; pre_reg_i = 8'd0;
      end
      if (c == restart_at + 1) cmd_reg_i[0] = 1'b0;
      if (c > 0 && !en_o && !status_reg_o[0]) break;
      tick(1);
    end
  endtask

  task automatic send(input logic [7:0] w);
    int t;
    data_i = w;
    cmd_reg_i[0] = 1'b1;
    tick(1);
    cmd_reg_i[0] = 1'b0;
    t = 0;
    while (en_o && t < 600) begin
      tick(1);
      t++;
    end
    check("send_done", t >= 600, 0);
    tick(10);
  endtask

  task automatic man_bit(input logic b);
    sda_man = b; scl_man = 1'b0;
    tick(3);
    scl_man = 1'b1;
    tick(3);
    scl_man = 1'b0;
  endtask

  int          en_cnt, busy_cnt, nbits, period;
  logic [15:0] bits;

  initial begin
    // Reset state
    do_reset();
    check("rst_status", status_reg_o, 8'h00);
    check("rst_count", rx_count_o, 3'd0);
    check("rst_data", data_o, 8'h00);
    check("rst_link", {en_o, sda_o, scl_o}, 3'b000);

    // Reset mid-TX
    pre_reg_i = 8'd3; data_i = 8'hA5;
    cmd_reg_i[0] = 1'b1;
    tick(1);
    cmd_reg_i[0] = 1'b0;
    tick(9);
    check("midtx_en_before", en_o, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    check("midtx_link", {en_o, sda_o, scl_o}, 3'b000);
    check("midtx_status", status_reg_o, 8'h00);
    check("midtx_count", rx_count_o, 3'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    tick(2);

    // P=1 frame of 0xA5
    pre_reg_i = 8'd1; data_i = 8'hA5;
    cmd_reg_i[0] = 1'b1;
    tick(1);
    cmd_reg_i[0] = 1'b0;
    check("tx_en_first", en_o, 1'b1);
    check("tx_sda_first", sda_o, 1'b1);
    check("tx_scl_first", scl_o, 1'b0);
    capture(-10, en_cnt, busy_cnt, bits, nbits, period);
    check("tx_en_cycles", en_cnt, 4 * NB);
    check("tx_busy_cycles", busy_cnt, 4 * NB);
    check("tx_bits", bits, frame_of(8'hA5));
    check("tx_nbits", nbits, NB);
    check("tx_scl_period", period, 4);
    check("tx_idle_link", {en_o, sda_o, scl_o}, 3'b000);

    // Start while busy and prescaler change mid-frame are ignored
    tick(3);
    pre_reg_i = 8'd3; data_i = 8'h5A;
    cmd_reg_i[0] = 1'b1;
    tick(1);
    cmd_reg_i[0] = 1'b0;
    capture(5, en_cnt, busy_cnt, bits, nbits, period);
    check("busy_start_en_cycles", en_cnt, 8 * NB);
    check("busy_start_bits", bits, frame_of(8'h5A));
    check("busy_start_period", period, 8);

    // Loopback of two words, then drain
    do_reset();
    loop = 1'b1; pre_reg_i = 8'd1;
    send(8'h3C);
    send(8'hC3);
    check("lb_count2", rx_count_o, 3'd2);
    check("lb_head0", data_o, 8'h3C);
    check("lb_valid", status_reg_o[1], 1'b1);
    pulse_cmd(1);
    check("lb_head1", data_o, 8'hC3);
    check("lb_count1", rx_count_o, 3'd1);
    pulse_cmd(1);
    check("lb_empty_data", data_o, 8'h00);
    check("lb_empty_valid", status_reg_o[1], 1'b0);
    check("lb_empty_count", rx_count_o, 3'd0);

    // Overflow: five words into a four-entry FIFO
    do_reset();
    pre_reg_i = 8'd0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    check("ovf_count", rx_count_o, 3'd4);
    check("ovf_full", status_reg_o[2], 1'b1);
    check("ovf_flag", status_reg_o[3], 1'b1);
    check("ovf_head", data_o, 8'h11);
    pulse_cmd(2);
    check("ovf_cleared", status_reg_o[3], 1'b0);
    check("ovf_still_full", status_reg_o[2], 1'b1);
    pulse_cmd(1);
    check("ovf_pop_head", data_o, 8'h22);
    check("ovf_pop_count", rx_count_o, 3'd3);
    check("ovf_pop_notfull", status_reg_o[2], 1'b0);

    // Truncated frame: three scl edges then en_i falls
    do_reset();
    loop = 1'b0;
    en_man = 1'b1;
    tick(4);
    man_bit(1'b1); man_bit(1'b0); man_bit(1'b1);
    en_man = 1'b0;
    tick(8);
    check("ferr_flag", status_reg_o[4], 1'b1);
    check("ferr_count", rx_count_o, 3'd0);
    check("ferr_valid", status_reg_o[1], 1'b0);
    pulse_cmd(2);
    check("ferr_cleared", status_reg_o[4], 1'b0);
    en_man = 1'b1;
    tick(4);
    en_man = 1'b0;
    tick(8);
    check("ferr_zero_bits", status_reg_o[4], 1'b0);
    pulse_cmd(1);
    check("pop_empty_count", rx_count_o, 3'd0);
    check("pop_empty_data", data_o, 8'h00);
    check("parity_bit_default", status_reg_o[5], 1'b0);

`ifdef SERIAL_LINK_PARITY_EN
    // 0x07 with wrong (zero) parity bit: word kept, parity_err set
    do_reset();
    en_man = 1'b1;
    tick(4);
    for (int i = 7; i >= 0; i--) man_bit((8'h07 >> i) & 1'b1);
    man_bit(1'b0);
    tick(3);
    en_man = 1'b0;
    tick(8);
    check("par_count", rx_count_o, 3'd1);
    check("par_data", data_o, 8'h07);
    check("par_err", status_reg_o[5], 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
